ram_fifo_controller: RTL and testbench
======================================

Name: ram_fifo_controller

Overview:
- Circular-queue controller that sits directly upstream of the single-port RAM block and owns its address, in_data and write_enable lines.
- Turns a push/pop request interface into serialized RAM write and read accesses.
- Tracks read/write pointers and occupancy, so the RAM behaves as a FIFO of depth 2**ADDRESS_WIDTH.
- Accesses are one at a time; the controller arbitrates simultaneous push and pop requests.

Parameters:
- ADDRESS_WIDTH, 5: RAM address width; FIFO depth DEPTH = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8: data word width; must match the RAM.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- push_req  input  1  request to enqueue push_data.
- push_data  input  DATA_WIDTH  word to enqueue; captured on the acceptance edge.
- push_ack  output  1  one-cycle pulse: push accepted.
- pop_req  input  1  request to dequeue.
- pop_data  output  DATA_WIDTH  dequeued word; held until the next pop completes.
- pop_valid  output  1  one-cycle pulse: pop_data updated.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDRESS_WIDTH+1  current occupancy.
- busy  output  1  high whenever state != IDLE.
- ram_address  output  ADDRESS_WIDTH  to RAM address.
- ram_in_data  output  DATA_WIDTH  to RAM in_data.
- ram_write_enable  output  1  to RAM write_enable.
- ram_out_data  input  DATA_WIDTH  from RAM out_data.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- On reset:
  - State goes to IDLE.
  - wr_ptr, rd_ptr and count are cleared to 0.
  - last_op is set to POP.
  - All outputs go to 0; empty=1, full=0.
- Reset mid-operation abandons the access. RAM contents are not cleared but are logically discarded.
- FSM states: IDLE, WRITE, READ_WAIT, READ_CAP.
- Request sampling:
  - push_req and pop_req are sampled only in IDLE.
  - A push is eligible when !full; a pop is eligible when !empty.
- Arbitration when both requests are eligible:
  - Serve the op opposite to last_op, so the first contested op after reset is a push.
  - If only one request is eligible, serve it.
  - An ineligible request is ignored: no ack, no state change.
- Push acceptance, IDLE -> WRITE on edge N:
  - Registers load ram_address<=wr_ptr, ram_in_data<=push_data, ram_write_enable<=1.
  - push_ack<=1 and last_op<=PUSH.
- WRITE -> IDLE on edge N+1:
  - The RAM writes on this edge.
  - ram_write_enable<=0, push_ack<=0.
  - wr_ptr<=wr_ptr+1 (mod DEPTH) and count<=count+1.
- Pop acceptance, IDLE -> READ_WAIT on edge N:
  - ram_address<=rd_ptr, ram_write_enable stays 0, last_op<=POP.
- READ_WAIT -> READ_CAP on edge N+1: no other action. ram_address is held, so both combinational-read and registered-read RAMs are served.
- READ_CAP -> IDLE on edge N+2:
  - pop_data<=ram_out_data, pop_valid<=1 for one cycle.
  - rd_ptr<=rd_ptr+1 (mod DEPTH) and count<=count-1.
- Throughput:
  - A held push_req gives one push every 2 cycles.
  - A held pop_req gives one pop every 3 cycles.
  - The requester should drop its request on seeing the ack/valid pulse.
- Pointers wrap naturally from DEPTH-1 to 0.
- full, empty and count are derived from the count register. Only one op is in flight at a time, so count never sees a simultaneous increment and decrement.
- ram_address and ram_in_data hold their last value while in IDLE.

Optional Feature:
- Macro: RAM_FIFO_CTRL_ERR_EN.
- When defined:
  - Adds output ports overflow (1) and underflow (1).
  - overflow sets when push_req is sampled in IDLE while full.
  - underflow sets when pop_req is sampled in IDLE while empty.
  - Both flags are sticky and cleared only by reset.
- When undefined: the ports and flags are absent; ineligible requests are silently ignored.

Test Plan:
- Fill:
  - Stimulus: after reset, 32 pushes of data i*3, i=0..31.
  - Response: 32 push_ack pulses; RAM addresses 0..31 hold 0,3,...,93; full=1 and count=32 after the last WRITE.
  - Then a 33rd push (data 0xFF) gets no ack, and overflow=1 when RAM_FIFO_CTRL_ERR_EN is defined.
- Drain: from full, 32 pops -> pop_valid pulses 3 cycles apart with pop_data 0,3,...,93 in order; then empty=1 and count=0.
  - A further pop gets no pop_valid, and underflow=1 when RAM_FIFO_CTRL_ERR_EN is defined.
- Arbitration: with count=4, hold push_req and pop_req together -> accepted ops alternate push, pop, push, pop, ...; count stays at 4 or 5.
- Wrap-around: push 20, pop 20, then push 20 -> writes hit addresses 20..31 then 0..7; popping 20 returns the second batch in order.
- Reset: assert reset during READ_WAIT -> outputs clear asynchronously; state IDLE, count=0, empty=1, no pop_valid pulse.

Source files
------------

// File: rtl/ram_fifo_controller.sv
// ram_fifo_controller
// FIFO controller that drives a single-port RAM as a circular queue of
// depth 2**ADDRESS_WIDTH. Push and pop requests become one RAM access at a
// time. When a push and a pop are both eligible, the controller alternates
// between them.
// Optional build macro RAM_FIFO_CTRL_ERR_EN adds two sticky error flags:
// overflow (push while full) and underflow (pop while empty).
module ram_fifo_controller #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_req,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic                     push_ack,
    input  logic                     pop_req,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_in_data,
    output logic                     ram_write_enable,
`ifdef RAM_FIFO_CTRL_ERR_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    input  logic [DATA_WIDTH-1:0]    ram_out_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = (ADDRESS_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_CAP
    } state_t;

    typedef enum logic {
        OP_POP,
        OP_PUSH
    } op_t;

    state_t                   state;
    state_t                   state_next;
    op_t                      last_op;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic                     push_ok;
    logic                     pop_ok;
    logic                     take_push;
    logic                     take_pop;

    // Occupancy flags come straight from the count register.
    assign full    = (count == DEPTH_COUNT);
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign push_ok = push_req && !full;
    assign pop_ok  = pop_req && !empty;

    // Next-state logic. When both requests are eligible, the controller
    // serves the operation opposite to the last one it served.
    always_comb begin
        state_next = state;
        take_push  = 1'b0;
        take_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (push_ok && pop_ok) begin
                    if (last_op == OP_POP) take_push = 1'b1;
                    else                   take_pop  = 1'b1;
                end else if (push_ok) begin
                    take_push = 1'b1;
                end else if (pop_ok) begin
                    take_pop = 1'b1;
                end
                if (take_push)     state_next = WRITE;
                else if (take_pop) state_next = READ_WAIT;
            end
            WRITE:     state_next = IDLE;
            READ_WAIT: state_next = READ_CAP;
            READ_CAP:  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register. An asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // RAM interface, pointers, occupancy and handshake pulses. The address
    // is held through READ_WAIT, so a RAM with either a combinational or a
    // registered read path has valid data by READ_CAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_address      <= '0;
            ram_in_data      <= '0;
            ram_write_enable <= 1'b0;
            push_ack         <= 1'b0;
            pop_valid        <= 1'b0;
            pop_data         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            last_op          <= OP_POP;
        end else begin
            push_ack  <= 1'b0;
            pop_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_push) begin
                        ram_address      <= wr_ptr;
                        ram_in_data      <= push_data;
                        ram_write_enable <= 1'b1;
                        push_ack         <= 1'b1;
                        last_op          <= OP_PUSH;
                    end else if (take_pop) begin
                        ram_address <= rd_ptr;
                        last_op     <= OP_POP;
                    end
                end
                WRITE: begin
                    ram_write_enable <= 1'b0;
                    wr_ptr           <= wr_ptr + 1'b1;
                    count            <= count + 1'b1;
                end
                READ_CAP: begin
                    pop_data  <= ram_out_data;
                    pop_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                    count     <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_FIFO_CTRL_ERR_EN
    // Sticky error flags. A request that arrives in IDLE but cannot be
    // served sets its flag, and only reset clears the flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (state == IDLE) begin
            if (push_req && full)  overflow  <= 1'b1;
            if (pop_req && empty)  underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_controller.sv
// Testbench for ram_fifo_controller. The bench models the RAM with
// combinational read and writes on clk. A queue holds the expected pop data
// and the bench tracks the expected write address, occupancy and last
// operation. Build with RAM_FIFO_CTRL_ERR_EN defined to cover the error flags.
module tb_ram_fifo_controller;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          reset;
    logic          push_req;
    logic [DW-1:0] push_data;
    logic          push_ack;
    logic          pop_req;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          busy;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_in_data;
    logic          ram_write_enable;
    logic [DW-1:0] ram_out_data;
`ifdef RAM_FIFO_CTRL_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    ram_fifo_controller #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_req         (push_req),
        .push_data        (push_data),
        .push_ack         (push_ack),
        .pop_req          (pop_req),
        .pop_data         (pop_data),
        .pop_valid        (pop_valid),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .busy             (busy),
        .ram_address      (ram_address),
        .ram_in_data      (ram_in_data),
        .ram_write_enable (ram_write_enable),
`ifdef RAM_FIFO_CTRL_ERR_EN
        .overflow         (overflow),
        .underflow        (underflow),
`endif
        .ram_out_data     (ram_out_data)
    );

    // Single-port RAM model: synchronous write, combinational read.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_address] <= ram_in_data;
    end
    assign ram_out_data = mem[ram_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cycle  = 0;
    logic [DW-1:0] sb[$];
    logic [AW-1:0] exp_wr;
    int            exp_count;
    bit            last_was_pop;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        bit got;
        got       = 1'b0;
        push_req  = 1'b1;
        push_data = d;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (push_ack) got = 1'b1;
        end
        push_req = 1'b0;
        check("push_ack", got, 1);
        if (got) begin
            check("push_addr", ram_address, exp_wr);
            check("push_wen", ram_write_enable, 1);
            check("push_wdata", ram_in_data, d);
            sb.push_back(d);
            exp_wr++;
            exp_count++;
            last_was_pop = 1'b0;
            tick();
            check("push_count", count, exp_count);
        end
    endtask

    task automatic pop_one();
        bit            got;
        logic [DW-1:0] exp_d;
        got     = 1'b0;
        pop_req = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (busy) pop_req = 1'b0;
            if (pop_valid) got = 1'b1;
        end
        pop_req = 1'b0;
        check("pop_valid", got, 1);
        if (got && sb.size() > 0) begin
            exp_d = sb.pop_front();
            check("pop_data", pop_data, exp_d);
            exp_count--;
            last_was_pop = 1'b1;
            check("pop_count", count, exp_count);
        end
    endtask

    initial begin
        bit got;
        int n;
        int last_cyc;
        int ops;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] next_d;

        reset     = 1'b1;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        push_data = '0;
        exp_wr    = '0;
        exp_count = 0;
        last_was_pop = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_push_ack", push_ack, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_wen", ram_write_enable, 0);
        check("rst_addr", ram_address, 0);
        reset = 1'b0;
        tick();

        // Fill: 32 pushes of i*3
        for (int i = 0; i < DEPTH; i++) push_one(DW'(i * 3));
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH);
        check("fill_empty", empty, 0);
        for (int i = 0; i < DEPTH; i++) check("fill_mem", mem[i], DW'(i * 3));

        // A push while full is ignored
        got       = 1'b0;
        push_req  = 1'b1;
        push_data = 8'hFF;
        repeat (4) begin
            tick();
            if (push_ack || busy) got = 1'b1;
        end
        push_req = 1'b0;
        check("full_push_ignored", got, 0);
        check("full_push_count", count, DEPTH);
`ifdef RAM_FIFO_CTRL_ERR_EN
        check("overflow_set", overflow, 1);
        check("underflow_clear", underflow, 0);
`endif

        // Drain with pop_req held: one pop every 3 cycles, data in order
        n        = 0;
        last_cyc = 0;
        pop_req  = 1'b1;
        for (int c = 0; c < 200 && n < DEPTH; c++) begin
            tick();
            if (pop_valid) begin
                exp_d = sb.pop_front();
                check("drain_data", pop_data, exp_d);
                if (n > 0) check("drain_interval", cycle - last_cyc, 3);
                last_cyc = cycle;
                n++;
                if (n == DEPTH) pop_req = 1'b0;
            end
        end
        pop_req = 1'b0;
        exp_count = 0;
        last_was_pop = 1'b1;
        check("drain_pops", n, DEPTH);
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);

        // A pop while empty is ignored
        got     = 1'b0;
        pop_req = 1'b1;
        repeat (5) begin
            tick();
            if (pop_valid || busy) got = 1'b1;
        end
        pop_req = 1'b0;
        check("empty_pop_ignored", got, 0);
`ifdef RAM_FIFO_CTRL_ERR_EN
        check("underflow_set", underflow, 1);
        check("overflow_sticky", overflow, 1);
`endif

        // Wrap-around: push 20, pop 20, push 20 (addresses 20..31, 0..7)
        for (int i = 0; i < 20; i++) push_one(8'h40 + DW'(i));
        for (int i = 0; i < 20; i++) pop_one();
        for (int i = 0; i < 20; i++) push_one(8'h80 + DW'(i));
        check("wrap_mem0", mem[0], 8'h8C);
        check("wrap_mem31", mem[31], 8'h8B);
        for (int i = 0; i < 20; i++) pop_one();
        check("wrap_empty", empty, 1);

        // Arbitration: reach count 4 with a pop as the last operation
        for (int i = 0; i < 5; i++) push_one(8'hC0 + DW'(i));
        pop_one();
        check("arb_start_count", count, 4);
        ops       = 0;
        next_d    = 8'hD0;
        push_data = next_d;
        push_req  = 1'b1;
        pop_req   = 1'b1;
        for (int c = 0; c < 100 && ops < 8; c++) begin
            tick();
            check("arb_count_range", (count == 4) || (count == 5), 1);
            if (push_ack) begin
                check("arb_push_turn", last_was_pop, 1);
                sb.push_back(next_d);
                exp_count++;
                last_was_pop = 1'b0;
                next_d    = next_d + 1'b1;
                push_data = next_d;
                ops++;
            end
            if (pop_valid) begin
                check("arb_pop_turn", last_was_pop, 0);
                exp_d = sb.pop_front();
                check("arb_pop_data", pop_data, exp_d);
                exp_count--;
                last_was_pop = 1'b1;
                ops++;
            end
            if (ops == 8) begin
                push_req = 1'b0;
                pop_req  = 1'b0;
            end
        end
        push_req = 1'b0;
        pop_req  = 1'b0;
        check("arb_ops", ops, 8);
        tick();
        check("arb_end_count", count, exp_count);

        // Reset during READ_WAIT
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        check("rw_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_pop_valid", pop_valid, 0);
        check("arst_push_ack", push_ack, 0);
        check("arst_addr", ram_address, 0);
        check("arst_wen", ram_write_enable, 0);
        check("arst_pop_data", pop_data, 0);
`ifdef RAM_FIFO_CTRL_ERR_EN
        check("arst_overflow", overflow, 0);
        check("arst_underflow", underflow, 0);
`endif
        tick();
        check("arst_hold_valid", pop_valid, 0);
        reset = 1'b0;
        tick();
        check("post_rst_valid", pop_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_empty", empty, 1);

        // Queue restarts from address 0
        sb.delete();
        exp_wr    = '0;
        exp_count = 0;
        last_was_pop = 1'b1;
        push_one(8'h5A);
        pop_one();
        check("final_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
